// File: rtl/fifo_reader.sv
// fifo_reader: pops a FIFO with one-cycle read latency into a
// 2-entry skid buffer and streams words downstream under dn_pause.
module fifo_reader #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic              fifo_valid,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              dn_pause,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  rd_count,
  output logic              err_rd
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    ERR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic              inflight_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic              pop;
  logic              push;
  logic              drained;
  logic [2:0]        credit;

  assign pop     = (occ_q != 2'd0) && !dn_pause
                && (state_q != ERR);
  assign push    = fifo_valid && inflight_q;
  assign drained = (occ_q == 2'd0) && !inflight_q;

  // occ + inflight - pop; pop implies occ > 0 so no underflow
  assign credit  = {1'b0, occ_q}
                 + {2'b00, inflight_q}
                 - {2'b00, pop};

  assign fifo_rd = !RESET && (state_q == RUN) && enable
                && !fifo_empty && (credit < 3'd2);

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign rd_count = cnt_q;
  assign err_rd   = err_q;

  // Next control state; an unsolicited read-data beat overrides all
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN:   if (!enable) state_d = drained ? IDLE : FLUSH;
      FLUSH: begin
        if (enable)       state_d = RUN;
        else if (drained) state_d = IDLE;
      end
      ERR:   state_d = ERR;
    endcase
    if (fifo_valid && !inflight_q) state_d = ERR;
  end

  // Skid buffer: shift out the head on pop, then append at the tail
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    if (pop) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) buf0_d = fifo_data;
      else               buf1_d = fifo_data;
      occ_d = occ_d + 2'd1;
    end
  end

  // State, buffer and output registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      inflight_q <= fifo_rd;
      valid_q    <= pop;
      if (pop) begin
        data_q <= buf0_q;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      if (state_d == ERR) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed table, hand sequences and random
// traffic checked against a queue-based reference model.
module tb_fifo_reader;

  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_valid;
  logic [DW-1:0] fifo_data;
  logic          dn_pause;
  logic          fifo_rd;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic [CW-1:0] rd_count;
  logic          err_rd;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .RESET      (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_valid (fifo_valid),
    .fifo_data  (fifo_data),
    .dn_pause   (dn_pause),
    .fifo_rd    (fifo_rd),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .rd_count   (rd_count),
    .err_rd     (err_rd)
  );

  int vec  = 0;
  int errs = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          r, e, m, v;
    logic [5:0]  d;
    bit          p;
    bit          xrd, xv;
    logic [5:0]  xd;
    logic [7:0]  xc;
    bit          xe;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit m, bit v,
                              logic [5:0] d, bit p,
                              bit xrd, bit xv,
                              logic [5:0] xd,
                              logic [7:0] xc, bit xe);
    vec_t t;
    t.r = r; t.e = e; t.m = m; t.v = v; t.d = d; t.p = p;
    t.xrd = xrd; t.xv = xv; t.xd = xd; t.xc = xc; t.xe = xe;
    return t;
  endfunction

  // reference model (transaction level, queue-based)
  typedef enum int {S_IDLE, S_RUN, S_FLUSH, S_ERR} mst_t;
  mst_t          mst = S_IDLE;
  logic [DW-1:0] mq[$];
  bit            minf = 0;
  bit            mval = 0;
  logic [DW-1:0] mdat = '0;
  logic [CW-1:0] mcnt = '0;
  bit            merr = 0;

  // FIFO environment
  logic [DW-1:0] src[$];
  logic [DW-1:0] got[$];
  bit            pend_v = 0;
  logic [DW-1:0] pend_d = '0;
  int            n_rd = 0;

  task automatic step(input bit r, input bit e, input bit p);
    bit   mpop, mrd, drd;
    int   tot;
    mst_t nx;
    rst        = r;
    enable     = e;
    dn_pause   = p;
    fifo_empty = (src.size() == 0);
    fifo_valid = pend_v;
    fifo_data  = pend_d;
    #1;
    mpop = (mq.size() > 0) && !p && (mst != S_ERR);
    tot  = mq.size() + int'(minf) - int'(mpop);
    mrd  = !r && (mst == S_RUN) && e && !fifo_empty
        && (tot < 2);
    chk("fifo_rd", fifo_rd, mrd);
    drd = (fifo_rd === 1'b1);
    if (drd) n_rd++;
    if (r) begin
      mst = S_IDLE; mq.delete(); minf = 0;
      mval = 0; mdat = '0; mcnt = '0; merr = 0;
    end else begin
      nx = mst;
      if (fifo_valid && !minf) nx = S_ERR;
      else if (mst == S_IDLE) begin
        if (e) nx = S_RUN;
      end else if (mst == S_RUN) begin
        if (!e) nx = (mq.size() == 0 && !minf)
                   ? S_IDLE : S_FLUSH;
      end else if (mst == S_FLUSH) begin
        if (e) nx = S_RUN;
        else if (mq.size() == 0 && !minf) nx = S_IDLE;
      end
      if (mpop) begin
        mval = 1;
        mdat = mq.pop_front();
        mcnt = mcnt + 1'b1;
      end else begin
        mval = 0;
      end
      if (fifo_valid && minf) mq.push_back(fifo_data);
      minf = mrd;
      mst  = nx;
      if (nx == S_ERR) merr = 1;
    end
    if (drd && src.size() > 0) begin
      pend_v = 1;
      pend_d = src.pop_front();
    end else begin
      pend_v = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("valid_o", valid_o, mval);
    chk("data_o", data_o, mdat);
    chk("rd_count", rd_count, mcnt);
    chk("err_rd", err_rd, merr);
    if (valid_o === 1'b1) got.push_back(data_o);
  endtask

  task automatic seq_start(input int n, input int base);
    src.delete();
    got.delete();
    step(1, 0, 0);
    for (int i = 0; i < n; i++)
      src.push_back(DW'((base + i) % 64));
    n_rd = 0;
  endtask

  vec_t tv[16];

  initial begin
    rst = 1; enable = 0; fifo_empty = 1;
    fifo_valid = 0; fifo_data = '0; dn_pause = 0;

    tv[0]  = mk(1,0,1,0,6'h00,0, 0,0,6'h00,8'd0,0);
    tv[1]  = mk(0,1,0,0,6'h00,0, 0,0,6'h00,8'd0,0);
    tv[2]  = mk(0,1,0,0,6'h00,0, 1,0,6'h00,8'd0,0);
    tv[3]  = mk(0,0,1,1,6'h15,0, 0,0,6'h00,8'd0,0);
    tv[4]  = mk(0,0,1,0,6'h00,1, 0,0,6'h00,8'd0,0);
    tv[5]  = mk(0,0,1,0,6'h00,0, 0,1,6'h15,8'd1,0);
    tv[6]  = mk(0,0,1,0,6'h00,0, 0,0,6'h15,8'd1,0);
    tv[7]  = mk(0,1,0,0,6'h00,0, 0,0,6'h15,8'd1,0);
    tv[8]  = mk(0,1,0,0,6'h00,0, 1,0,6'h15,8'd1,0);
    tv[9]  = mk(1,1,0,1,6'h2A,0, 0,0,6'h00,8'd0,0);
    tv[10] = mk(0,0,1,1,6'h2A,0, 0,0,6'h00,8'd0,1);
    tv[11] = mk(0,1,0,0,6'h00,0, 0,0,6'h00,8'd0,1);
    tv[12] = mk(0,1,0,0,6'h00,0, 0,0,6'h00,8'd0,1);
    tv[13] = mk(1,0,1,0,6'h00,0, 0,0,6'h00,8'd0,0);
    tv[14] = mk(0,1,1,1,6'h03,0, 0,0,6'h00,8'd0,1);
    tv[15] = mk(1,0,1,0,6'h00,0, 0,0,6'h00,8'd0,0);

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rst        = tv[i].r;
      enable     = tv[i].e;
      fifo_empty = tv[i].m;
      fifo_valid = tv[i].v;
      fifo_data  = tv[i].d;
      dn_pause   = tv[i].p;
      #1;
      chk($sformatf("t%0d_rd", i), fifo_rd, tv[i].xrd);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t%0d_valid", i), valid_o, tv[i].xv);
      chk($sformatf("t%0d_data", i), data_o, tv[i].xd);
      chk($sformatf("t%0d_cnt", i), rd_count, tv[i].xc);
      chk($sformatf("t%0d_err", i), err_rd, tv[i].xe);
    end

    // five preloaded words streamed straight through
    seq_start(5, 1);
    for (int i = 0; i < 12; i++) step(0, 1, 0);
    chk("s1_rds", n_rd, 5);
    chk("s1_cnt", rd_count, 5);
    chk("s1_err", err_rd, 0);
    chk("s1_len", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++)
      chk($sformatf("s1_w%0d", i), got[i], i + 1);

    // downstream stall for four cycles mid-stream
    seq_start(12, 10);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    chk("s2_cnt", rd_count, 12);
    chk("s2_len", got.size(), 12);
    for (int i = 0; i < got.size() && i < 12; i++)
      chk($sformatf("s2_w%0d", i), got[i], 10 + i);

    // enable dropped with one buffered and one in flight
    seq_start(8, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    chk("s3_rds", n_rd, 2);
    chk("s3_cnt", rd_count, 2);
    chk("s3_len", got.size(), 2);
    for (int i = 0; i < got.size() && i < 2; i++)
      chk($sformatf("s3_w%0d", i), got[i], i + 1);

    // counter wrap after 257 deliveries
    seq_start(257, 0);
    for (int i = 0; i < 270; i++) step(0, 1, 0);
    chk("s4_len", got.size(), 257);
    chk("s4_cnt", rd_count, 1);

    // reset in the middle of a stream
    seq_start(10, 5);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    step(1, 1, 0);
    chk("s5_valid", valid_o, 0);
    chk("s5_data", data_o, 0);
    chk("s5_cnt", rd_count, 0);
    chk("s5_err", err_rd, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);

    // random traffic
    src.delete();
    step(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) != 0 && src.size() < 8)
        src.push_back(DW'($urandom_range(0, 63)));
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
